calc_controle: RTL and testbench

Keypad-driven sequencer for the calculator's 4-bit single-digit adder (SOMA). It collects operand A, the '+' operator, operand B and '=' from a debounced keypad. It then drives SOMA's operands and its `agora` enable for one cycle and captures the sum. Results 0..15 are presented as two BCD display digits. Sums above 15 are detected independently and raise an error. The block sits between the keypad decoder and the display driver.

---
 rtl/calc_pkg.sv | 26 ++
 rtl/bin_para_bcd4.sv | 21 ++
 rtl/calc_controle.sv | 173 +++++++++++++++++
 tb/tb_calc_controle.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator keypad controllers.
// Contents: sequencer state encoding, keypad key codes, the display error
// marker and a digit-test helper.
package calc_pkg;

  typedef enum logic [2:0] {
    ESPERA_A  = 3'd0,
    ESPERA_OP = 3'd1,
    ESPERA_B  = 3'd2,
    ESPERA_IG = 3'd3,
    CALCULA   = 3'd4,
    MOSTRA    = 3'd5,
    ERRO      = 3'd6
  } estado_t;

  localparam logic [3:0] TECLA_MAIS  = 4'd10;
  localparam logic [3:0] TECLA_IGUAL = 4'd14;
  localparam logic [3:0] TECLA_LIMPA = 4'd15;
  localparam logic [3:0] DISP_ERRO   = 4'hE;

  // Key codes 0..9 are decimal digits.
  function automatic logic eh_digito(input logic [3:0] t);
    return t <= 4'd9;
  endfunction

endpackage

// File: rtl/bin_para_bcd4.sv
// bin_para_bcd4: combinational 4-bit binary to two-digit BCD converter.
// Ports:
//   bin  in  4  binary value 0..15
//   dez  out 4  tens digit (0 or 1)
//   uni  out 4  units digit (0..9)
module bin_para_bcd4 (
  input  logic [3:0] bin,
  output logic [3:0] dez,
  output logic [3:0] uni
);

  always_comb begin
    dez = 4'd0;
    uni = bin;
    if (bin >= 4'd10) begin
      dez = 4'd1;
      uni = bin - 4'd10;
    end
  end

endmodule

// File: rtl/calc_controle.sv
// calc_controle: keypad-driven sequencer for the 4-bit single-digit adder.
// Collects A, '+', B, '=' from the keypad, enables the external adder for one
// cycle, then shows the sum as two BCD digits or flags an overflow error.
// Ports:
//   clk           in   1  system clock, rising edge
//   rst_n         in   1  asynchronous active-low reset
//   tecla_valida  in   1  one-cycle key strobe
//   tecla         in   4  key code (0-9 digit, 10 '+', 14 '=', 15 'C')
//   op_a, op_b    out  4  operands to the adder
//   agora         out  1  adder enable, high only in CALCULA
//   soma_s        in   4  adder sum
//   disp_dez      out  4  tens display digit (4'hE on error)
//   disp_uni      out  4  units display digit
//   pronto        out  1  one-cycle pulse when a valid result is shown
//   erro          out  1  high while in ERRO
//   estado        out  3  current state, for debug
module calc_controle
  import calc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CICLOS = 0,
  parameter int unsigned TW             = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tecla_valida,
  input  logic [3:0] tecla,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic       agora,
  input  logic [3:0] soma_s,
  output logic [3:0] disp_dez,
  output logic [3:0] disp_uni,
  output logic       pronto,
  output logic       erro,
  output logic [2:0] estado
);

  localparam bit          TimeoutOn = (TIMEOUT_CICLOS != 0);
  localparam int unsigned CntMaxInt = TimeoutOn ? TIMEOUT_CICLOS - 1 : 0;
  localparam logic [TW-1:0] CntMax  = TW'(CntMaxInt);

  estado_t       state_q, state_d;
  logic [3:0]    op_a_q, op_a_d, op_b_q, op_b_d;
  logic [3:0]    dez_q, dez_d, uni_q, uni_d;
  logic          pronto_q, pronto_d, erro_q, erro_d;
  logic [TW-1:0] cnt_q, cnt_d;

  logic [3:0] soma_dez, soma_uni;
  logic [4:0] soma_ref;
  logic       digito, limpa, em_espera, expira;

  bin_para_bcd4 u_bcd (
    .bin (soma_s),
    .dez (soma_dez),
    .uni (soma_uni)
  );

  // Overflow is judged on our own operands so it never depends on the adder.
  assign soma_ref  = {1'b0, op_a_q} + {1'b0, op_b_q};
  assign digito    = tecla_valida && eh_digito(tecla);
  assign em_espera = (state_q == ESPERA_OP) || (state_q == ESPERA_B) ||
                     (state_q == ESPERA_IG);
  // A strobe on the expiry cycle wins over the timeout.
  assign expira    = TimeoutOn && em_espera && !tecla_valida && (cnt_q == CntMax);
  assign limpa     = (tecla_valida && (tecla == TECLA_LIMPA)) || expira;

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    dez_d    = dez_q;
    uni_d    = uni_q;
    pronto_d = 1'b0;
    erro_d   = erro_q;

    if (limpa) begin
      state_d = ESPERA_A;
      op_a_d  = 4'd0;
      op_b_d  = 4'd0;
      dez_d   = 4'd0;
      uni_d   = 4'd0;
      erro_d  = 1'b0;
    end else begin
      unique case (state_q)
        ESPERA_A, ESPERA_OP: begin
          if (digito) begin
            op_a_d  = tecla;
            dez_d   = 4'd0;
            uni_d   = tecla;
            state_d = ESPERA_OP;
          end else if (state_q == ESPERA_OP && tecla_valida && tecla == TECLA_MAIS) begin
            state_d = ESPERA_B;
          end
        end
        ESPERA_B, ESPERA_IG: begin
          if (digito) begin
            op_b_d  = tecla;
            dez_d   = 4'd0;
            uni_d   = tecla;
            state_d = ESPERA_IG;
          end else if (state_q == ESPERA_IG && tecla_valida && tecla == TECLA_IGUAL) begin
            state_d = CALCULA;
          end
        end
        CALCULA: begin
          if (soma_ref > 5'd15) begin
            state_d = ERRO;
            erro_d  = 1'b1;
            dez_d   = DISP_ERRO;
            uni_d   = DISP_ERRO;
          end else begin
            state_d  = MOSTRA;
            dez_d    = soma_dez;
            uni_d    = soma_uni;
            pronto_d = 1'b1;
          end
        end
        MOSTRA: begin
          // A digit starts a fresh calculation; no operator chaining.
          if (digito) begin
            op_a_d  = tecla;
            op_b_d  = 4'd0;
            dez_d   = 4'd0;
            uni_d   = tecla;
            state_d = ESPERA_OP;
          end
        end
        ERRO: ;
        default: state_d = ESPERA_A;
      endcase
    end
  end

  // Inactivity counter: reloads on any strobe or state change.
  always_comb begin
    cnt_d = '0;
    if (TimeoutOn && em_espera && !tecla_valida && (state_d == state_q)) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ESPERA_A;
      op_a_q   <= 4'd0;
      op_b_q   <= 4'd0;
      dez_q    <= 4'd0;
      uni_q    <= 4'd0;
      pronto_q <= 1'b0;
      erro_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      dez_q    <= dez_d;
      uni_q    <= uni_d;
      pronto_q <= pronto_d;
      erro_q   <= erro_d;
      cnt_q    <= cnt_d;
    end
  end

  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign agora    = (state_q == CALCULA);
  assign disp_dez = dez_q;
  assign disp_uni = uni_q;
  assign pronto   = pronto_q;
  assign erro     = erro_q;
  assign estado   = state_q;

endmodule

// File: tb/tb_calc_controle.sv
module tb_calc_controle;

  localparam logic [3:0] K_MAIS  = 4'd10;
  localparam logic [3:0] K_IGUAL = 4'd14;
  localparam logic [3:0] K_LIMPA = 4'd15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tecla_valida = 1'b0;
  logic [3:0] tecla = 4'd0;

  logic [3:0] op_a, op_b, soma_s, disp_dez, disp_uni;
  logic       agora, pronto, erro;
  logic [2:0] estado;

  logic [3:0] op_a2, op_b2, soma_s2, disp_dez2, disp_uni2;
  logic       agora2, pronto2, erro2;
  logic [2:0] estado2;

  // Adder models: sum only meaningful while enabled.
  assign soma_s  = agora  ? op_a + op_b   : 4'd0;
  assign soma_s2 = agora2 ? op_a2 + op_b2 : 4'd0;

  calc_controle #(.TIMEOUT_CICLOS(8), .TW(32)) dut (
    .clk(clk), .rst_n(rst_n), .tecla_valida(tecla_valida), .tecla(tecla),
    .op_a(op_a), .op_b(op_b), .agora(agora), .soma_s(soma_s),
    .disp_dez(disp_dez), .disp_uni(disp_uni), .pronto(pronto), .erro(erro),
    .estado(estado)
  );

  // No-timeout instance, same stimulus.
  calc_controle dut_nt (
    .clk(clk), .rst_n(rst_n), .tecla_valida(tecla_valida), .tecla(tecla),
    .op_a(op_a2), .op_b(op_b2), .agora(agora2), .soma_s(soma_s2),
    .disp_dez(disp_dez2), .disp_uni(disp_uni2), .pronto(pronto2), .erro(erro2),
    .estado(estado2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] dez;
    logic [3:0] uni;
    logic       erro;
  } vec_t;

  typedef struct {
    logic [3:0] dez;
    logic [3:0] uni;
    logic       erro;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Called at a falling edge; the key is taken at the next rising edge.
  task automatic press(input logic [3:0] k);
    tecla        = k;
    tecla_valida = 1'b1;
    @(negedge clk);
    tecla_valida = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_result(input string tag);
    exp_t e;
    int   n;
    bit   seen;
    seen = 1'b0;
    for (n = 0; n < 5; n++) begin
      @(negedge clk);
      if (pronto || erro) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s result: got no pronto/erro, expected one within 1 cycle", tag);
    end else if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: got result, expected none queued", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " latency"}, n, 0);
      check({tag, " dez"}, int'(disp_dez), int'(e.dez));
      check({tag, " uni"}, int'(disp_uni), int'(e.uni));
      check({tag, " erro"}, int'(erro), int'(e.erro));
      check({tag, " pronto"}, int'(pronto), int'(!e.erro));
      check({tag, " estado"}, int'(estado), e.erro ? 6 : 5);
      @(negedge clk);
      check({tag, " pronto pulse"}, int'(pronto), 0);
    end
  endtask

  task automatic calc(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input exp_t e);
    press(a);
    press(K_MAIS);
    press(b);
    sb.push_back(e);
    press(K_IGUAL);
    check({tag, " agora"}, int'(agora), 1);
    check({tag, " op_a"}, int'(op_a), int'(a));
    check({tag, " op_b"}, int'(op_b), int'(b));
    wait_result(tag);
  endtask

  initial begin
    exp_t e;
    vecs[0] = '{4'd3, 4'd4, 4'd0, 4'd7, 1'b0};
    vecs[1] = '{4'd9, 4'd6, 4'd1, 4'd5, 1'b0};
    vecs[2] = '{4'd8, 4'd8, 4'hE, 4'hE, 1'b1};
    vecs[3] = '{4'd0, 4'd0, 4'd0, 4'd0, 1'b0};
    vecs[4] = '{4'd5, 4'd5, 4'd1, 4'd0, 1'b0};
    vecs[5] = '{4'd7, 4'd9, 4'hE, 4'hE, 1'b1};
    vecs[6] = '{4'd9, 4'd9, 4'hE, 4'hE, 1'b1};
    vecs[7] = '{4'd1, 4'd9, 4'd1, 4'd0, 1'b0};
    vecs[8] = '{4'd6, 4'd3, 4'd0, 4'd9, 1'b0};

    #12 rst_n = 1'b1;
    @(negedge clk);
    check("reset estado", int'(estado), 0);
    check("reset op_a", int'(op_a), 0);
    check("reset op_b", int'(op_b), 0);
    check("reset disp", int'({disp_dez, disp_uni}), 0);
    check("reset flags", int'({agora, pronto, erro}), 0);

    // Table of complete calculations.
    for (int i = 0; i < 9; i++) begin
      e = '{vecs[i].dez, vecs[i].uni, vecs[i].erro};
      calc($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, e);
      press(K_LIMPA);
      check($sformatf("vec%0d clear", i), int'(estado), 0);
    end

    // ERRO holds until 'C'.
    e = '{4'hE, 4'hE, 1'b1};
    calc("erro", 4'd8, 4'd8, e);
    press(K_IGUAL);
    check("erro after =", int'(estado), 6);
    press(4'd3);
    check("erro after digit", int'(estado), 6);
    check("erro disp", int'({disp_dez, disp_uni}), 'hEE);
    press(K_LIMPA);
    check("erro C estado", int'(estado), 0);
    check("erro C disp", int'({disp_dez, disp_uni}), 0);
    check("erro C flag", int'(erro), 0);

    // Operand replacement and ignored keys.
    press(4'd2);
    check("rep A2", int'(op_a), 2);
    press(4'd5);
    check("rep A5", int'(op_a), 5);
    check("rep A disp", int'(disp_uni), 5);
    press(K_IGUAL);
    check("= in OP", int'(estado), 1);
    press(K_MAIS);
    press(4'd12);
    check("key12 in B", int'(estado), 2);
    press(K_IGUAL);
    check("= in B", int'(estado), 2);
    press(4'd1);
    check("rep B1", int'(op_b), 1);
    press(4'd7);
    press(K_MAIS);
    check("+ in IG", int'(estado), 3);
    check("rep B7", int'(op_b), 7);
    sb.push_back('{4'd1, 4'd2, 1'b0});
    press(K_IGUAL);
    wait_result("rep");
    press(K_MAIS);
    check("+ in MOSTRA", int'(estado), 5);
    press(4'd4);
    check("MOSTRA digit estado", int'(estado), 1);
    check("MOSTRA digit ops", int'({op_a, op_b}), 'h40);
    check("MOSTRA digit disp", int'({disp_dez, disp_uni}), 'h04);
    press(K_LIMPA);

    // Timeout expiry after 8 idle cycles.
    press(4'd4);
    press(K_MAIS);
    idle(7);
    check("to before", int'(estado), 2);
    idle(1);
    check("to expired", int'(estado), 0);
    check("to op_a", int'(op_a), 0);
    check("to disabled", int'(estado2), 2);
    idle(20);
    check("to disabled long", int'(estado2), 2);
    press(K_LIMPA);

    // Strobe on the expiry cycle wins, then the counter restarts.
    press(4'd4);
    press(K_MAIS);
    idle(7);
    press(4'd6);
    check("to strobe estado", int'(estado), 3);
    check("to strobe ops", int'({op_a, op_b}), 'h46);
    idle(7);
    check("to reload", int'(estado), 3);
    idle(1);
    check("to reload expired", int'(estado), 0);
    press(K_LIMPA);

    // Asynchronous reset during CALCULA.
    press(4'd1);
    press(K_MAIS);
    press(4'd1);
    press(K_IGUAL);
    check("rst agora before", int'(agora), 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst agora", int'(agora), 0);
    check("rst estado", int'(estado), 0);
    check("rst outs", int'({op_a, op_b, disp_dez, disp_uni, pronto, erro}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check("rst no result", int'({pronto, estado}), 0);
    e = '{4'd0, 4'd2, 1'b0};
    calc("post rst", 4'd1, 4'd1, e);

    check("scoreboard empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
